// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//   Main control FSM for a multicycle MIPS-style datapath. The state register
//   advances on every rising clock edge; all datapath controls are decoded
//   combinationally from the current state plus the OpCode/Funct fields of the
//   instruction register.
//
// Ports
//   clk          in   system clock, rising edge active
//   reset        in   synchronous reset, active low (0 = reset)
//   OpCode[5:0]  in   Instruction[31:26] from the instruction register
//   Funct[5:0]   in   Instruction[5:0]
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
//   ExtOp, LuiOp out  1-bit datapath controls
//   RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource  out  2-bit mux selects
//   ALUOp[3:0]   out  operation class for the ALU-control decoder
//   State[3:0]   out  current FSM state (debug)
//   IllegalOp    out  sticky illegal-opcode flag
//
// Configuration
//   ILLEGAL_OP_TRAP_EN  when defined, an unknown opcode sets IllegalOp and
//                       parks the FSM in HALT until reset. When undefined,
//                       an unknown opcode is a 2-cycle NOP and IllegalOp is 0.
// ---------------------------------------------------------------------------
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ExtOp,
    output logic       LuiOp,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOp,
    output logic [3:0] State,
    output logic       IllegalOp
);

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_LWWB   = 4'd4,
        S_SW     = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    state_t state_r;
    state_t next_state_s;

    // Register jumps (jr/jalr) are R-type but take the JUMP path.
    function automatic logic is_reg_jump(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_RTYPE) && ((fn == FN_JR) || (fn == FN_JALR));
    endfunction

    // Constant shifts take their first ALU operand from the shamt field.
    function automatic logic is_const_shift(input logic [5:0] fn);
        return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
    endfunction

    // State register; reset wins over every state, HALT included.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= S_IF;
        end else begin
            state_r <= next_state_s;
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_r;

    // Sticky flag, set on the ID->HALT transition and cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            illegal_r <= 1'b0;
        end else if ((state_r == S_ID) && (next_state_s == S_HALT)) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign IllegalOp = illegal_r;
`else
    assign IllegalOp = 1'b0;
`endif

    assign State = state_r;

    // Next-state logic: instruction dispatch in ID, fixed successors elsewhere.
    always_comb begin
        next_state_s = S_IF;
        case (state_r)
            S_IF: begin
                next_state_s = S_ID;
            end
            S_ID: begin
                case (OpCode)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_BEQ:       next_state_s = S_BRANCH;
                    OP_J, OP_JAL: next_state_s = S_JUMP;
                    OP_RTYPE: begin
                        if (is_reg_jump(OpCode, Funct)) begin
                            next_state_s = S_JUMP;
                        end else begin
                            next_state_s = S_EXEC;
                        end
                    end
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU, OP_LUI: begin
                        next_state_s = S_EXEC;
                    end
                    default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                        next_state_s = S_HALT;
`else
                        next_state_s = S_IF;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                if (OpCode == OP_LW) begin
                    next_state_s = S_MEMRD;
                end else if (OpCode == OP_SW) begin
                    next_state_s = S_SW;
                end else begin
                    next_state_s = S_IF;
                end
            end
            S_MEMRD:  next_state_s = S_LWWB;
            S_LWWB:   next_state_s = S_IF;
            S_SW:     next_state_s = S_IF;
            S_EXEC:   next_state_s = S_ALUWB;
            S_ALUWB:  next_state_s = S_IF;
            S_BRANCH: next_state_s = S_IF;
            S_JUMP:   next_state_s = S_IF;
            S_HALT: begin
`ifdef ILLEGAL_OP_TRAP_EN
                next_state_s = S_HALT;
`else
                next_state_s = S_IF;
`endif
            end
            default:  next_state_s = S_IF;
        endcase
    end

    // Output decode: Moore per state, qualified by OpCode/Funct where needed.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ExtOp       = 1'b0;
        LuiOp       = 1'b0;
        RegDst      = 2'd0;
        MemtoReg    = 2'd0;
        ALUSrcA     = 2'd0;
        ALUSrcB     = 2'd0;
        PCSource    = 2'd0;
        ALUOp       = 4'b0000;
        case (state_r)
            S_IF: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = 2'd1;
                PCWrite = 1'b1;
            end
            S_ID: begin
                // Branch target PC+4+(imm<<2) is computed here into ALUOut.
                ALUSrcB = 2'd3;
                ExtOp   = 1'b1;
            end
            S_MEMADR: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                ExtOp   = 1'b1;
                ALUOp   = 4'b0100;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_LWWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'd1;
            end
            S_SW: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                if (OpCode == OP_RTYPE) begin
                    ALUSrcA = is_const_shift(Funct) ? 2'd2 : 2'd1;
                    ALUOp   = 4'b0011;
                end else begin
                    ALUSrcA = 2'd1;
                    ALUSrcB = 2'd2;
                    ExtOp   = 1'b1;
                    case (OpCode)
                        OP_ADDI:  ALUOp = 4'b0100;
                        OP_ADDIU: ALUOp = 4'b0000;
                        OP_SLTI:  ALUOp = 4'b0101;
                        OP_SLTIU: ALUOp = 4'b0001;
                        OP_ANDI: begin
                            ALUOp = 4'b0110;
                            ExtOp = 1'b0;
                        end
                        OP_LUI:   LuiOp = 1'b1;
                        default:  ALUOp = 4'b0000;
                    endcase
                end
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = (OpCode == OP_RTYPE) ? 2'd1 : 2'd0;
            end
            S_BRANCH: begin
                ALUSrcA     = 2'd1;
                ALUOp       = 4'b0010;
                PCWriteCond = 1'b1;
                PCSource    = 2'd1;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                if ((OpCode == OP_J) || (OpCode == OP_JAL)) begin
                    PCSource = 2'd2;
                    if (OpCode == OP_JAL) begin
                        RegWrite = 1'b1;
                        MemtoReg = 2'd2;
                        RegDst   = 2'd2;
                    end else begin
                        RegWrite = 1'b0;
                    end
                end else begin
                    PCSource = 2'd3;
                    if (Funct == FN_JALR) begin
                        RegWrite = 1'b1;
                        MemtoReg = 2'd2;
                        RegDst   = 2'd1;
                    end else begin
                        RegWrite = 1'b0;
                    end
                end
            end
            S_HALT: begin
                PCWrite = 1'b0;
            end
            default: begin
                PCWrite = 1'b0;
            end
        endcase

        // No architectural write may happen while reset is held.
        if (!reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            MemWrite    = 1'b0;
            MemRead     = 1'b0;
        end else begin
            IorD = IorD;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//   Directed scoreboard bench. The stimulus process drives OpCode/Funct/reset
//   once per cycle and pushes the hand-derived expected State, control word
//   and IllegalOp for that cycle; a monitor on the falling edge pops and
//   compares against the DUT outputs.
//   Honours ILLEGAL_OP_TRAP_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       RegWrite, ExtOp, LuiOp;
    logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
    logic [3:0] ALUOp;
    logic [3:0] State;
    logic       IllegalOp;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ExtOp(ExtOp), .LuiOp(LuiOp),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
        .State(State), .IllegalOp(IllegalOp)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0]  st;
        logic [22:0] w;
        logic        ill;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    // Control word order:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,RegWrite,ExtOp,LuiOp,
    //  RegDst,MemtoReg,ALUSrcA,ALUSrcB,PCSource,ALUOp}
    function automatic logic [22:0] cw(
        input logic pcw, input logic pcwc, input logic iord, input logic mr,
        input logic mw, input logic irw, input logic rw, input logic ext,
        input logic lui, input logic [1:0] rd, input logic [1:0] m2r,
        input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] ps,
        input logic [3:0] op);
        return {pcw, pcwc, iord, mr, mw, irw, rw, ext, lui, rd, m2r, sa, sb, ps, op};
    endfunction

    logic [22:0] w_rst, w_if, w_id, w_memadr, w_memrd, w_memrd_rst, w_lwwb, w_sw;
    logic [22:0] w_exec_sh, w_exec_r, w_aluwb_r, w_aluwb_i, w_branch;
    logic [22:0] w_jal, w_j, w_jr, w_jalr;
    logic [22:0] w_andi, w_sltiu, w_addi, w_lui, w_zero;

    // Monitor: one comparison per expected entry, on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t  e;
            string n;
            logic [22:0] act_w;
            e     = exp_q.pop_front();
            n     = name_q.pop_front();
            act_w = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     RegWrite, ExtOp, LuiOp, RegDst, MemtoReg, ALUSrcA,
                     ALUSrcB, PCSource, ALUOp};
            checks++;
            if ((State !== e.st) || (act_w !== e.w) || (IllegalOp !== e.ill)) begin
                errors++;
                $display("FAIL %s: got State=%0d ctl=%h IllegalOp=%b, want State=%0d ctl=%h IllegalOp=%b",
                         n, State, act_w, IllegalOp, e.st, e.w, e.ill);
            end
        end
    end

    // Push the expectation for the current cycle, then advance one cycle.
    task automatic cyc(input string nm, input logic [3:0] st,
                       input logic [22:0] w, input logic ill);
        exp_t e;
        e.st  = st;
        e.w   = w;
        e.ill = ill;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        OpCode = op;
        Funct  = fn;
    endtask

    initial begin
        w_rst       = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd1,2'd0,4'b0000);
        w_if        = cw(1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd1,2'd0,4'b0000);
        w_id        = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,2'd0,2'd0,2'd3,2'd0,4'b0000);
        w_memadr    = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,2'd0,2'd1,2'd2,2'd0,4'b0100);
        w_memrd     = cw(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,2'd0,4'b0000);
        w_memrd_rst = cw(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,2'd0,4'b0000);
        w_lwwb      = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,2'd1,2'd0,2'd0,2'd0,4'b0000);
        w_sw        = cw(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,2'd0,4'b0000);
        w_exec_sh   = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd2,2'd0,2'd0,4'b0011);
        w_exec_r    = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd1,2'd0,2'd0,4'b0011);
        w_aluwb_r   = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd1,2'd0,2'd0,2'd0,2'd0,4'b0000);
        w_aluwb_i   = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,2'd0,4'b0000);
        w_branch    = cw(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd1,2'd0,2'd1,4'b0010);
        w_jal       = cw(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd2,2'd2,2'd0,2'd0,2'd2,4'b0000);
        w_j         = cw(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,2'd2,4'b0000);
        w_jr        = cw(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,2'd3,4'b0000);
        w_jalr      = cw(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd1,2'd2,2'd0,2'd0,2'd3,4'b0000);
        w_andi      = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd1,2'd2,2'd0,4'b0110);
        w_sltiu     = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,2'd0,2'd1,2'd2,2'd0,4'b0001);
        w_addi      = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,2'd0,2'd1,2'd2,2'd0,4'b0100);
        w_lui       = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'd0,2'd0,2'd1,2'd2,2'd0,4'b0000);
        w_zero      = 23'd0;

        reset = 1'b0;
        set_instr(6'h00, 6'h00);
        @(posedge clk);
        #1;

        // Two reset cycles: IF state with every write enable forced low.
        cyc("rst_c0", 4'd0, w_rst, 1'b0);
        cyc("rst_c1", 4'd0, w_rst, 1'b0);

        // lw: 5 cycles, first fetch in the first cycle with reset high.
        reset = 1'b1;
        set_instr(6'h23, 6'h00);
        cyc("lw_if", 4'd0, w_if, 1'b0);
        cyc("lw_id", 4'd1, w_id, 1'b0);
        cyc("lw_memadr", 4'd2, w_memadr, 1'b0);
        cyc("lw_memrd", 4'd3, w_memrd, 1'b0);
        cyc("lw_wb", 4'd4, w_lwwb, 1'b0);

        // sw: 4 cycles.
        set_instr(6'h2b, 6'h15);
        cyc("sw_if", 4'd0, w_if, 1'b0);
        cyc("sw_id", 4'd1, w_id, 1'b0);
        cyc("sw_memadr", 4'd2, w_memadr, 1'b0);
        cyc("sw_sw", 4'd5, w_sw, 1'b0);

        // srl: shift takes shamt as ALU operand A.
        set_instr(6'h00, 6'h02);
        cyc("srl_if", 4'd0, w_if, 1'b0);
        cyc("srl_id", 4'd1, w_id, 1'b0);
        cyc("srl_exec", 4'd6, w_exec_sh, 1'b0);
        cyc("srl_aluwb", 4'd7, w_aluwb_r, 1'b0);

        // add: register operand A.
        set_instr(6'h00, 6'h20);
        cyc("add_if", 4'd0, w_if, 1'b0);
        cyc("add_id", 4'd1, w_id, 1'b0);
        cyc("add_exec", 4'd6, w_exec_r, 1'b0);
        cyc("add_aluwb", 4'd7, w_aluwb_r, 1'b0);

        // Unlisted Funct still takes the EXEC path.
        set_instr(6'h00, 6'h3e);
        cyc("rfn_if", 4'd0, w_if, 1'b0);
        cyc("rfn_id", 4'd1, w_id, 1'b0);
        cyc("rfn_exec", 4'd6, w_exec_r, 1'b0);
        cyc("rfn_aluwb", 4'd7, w_aluwb_r, 1'b0);

        // beq: 3 cycles.
        set_instr(6'h04, 6'h00);
        cyc("beq_if", 4'd0, w_if, 1'b0);
        cyc("beq_id", 4'd1, w_id, 1'b0);
        cyc("beq_branch", 4'd8, w_branch, 1'b0);

        // Jumps: jal, j, jr, jalr.
        set_instr(6'h03, 6'h00);
        cyc("jal_if", 4'd0, w_if, 1'b0);
        cyc("jal_id", 4'd1, w_id, 1'b0);
        cyc("jal_jump", 4'd9, w_jal, 1'b0);
        set_instr(6'h02, 6'h09);
        cyc("j_if", 4'd0, w_if, 1'b0);
        cyc("j_id", 4'd1, w_id, 1'b0);
        cyc("j_jump", 4'd9, w_j, 1'b0);
        set_instr(6'h00, 6'h08);
        cyc("jr_if", 4'd0, w_if, 1'b0);
        cyc("jr_id", 4'd1, w_id, 1'b0);
        cyc("jr_jump", 4'd9, w_jr, 1'b0);
        set_instr(6'h00, 6'h09);
        cyc("jalr_if", 4'd0, w_if, 1'b0);
        cyc("jalr_id", 4'd1, w_id, 1'b0);
        cyc("jalr_jump", 4'd9, w_jalr, 1'b0);

        // I-type ALU ops.
        set_instr(6'h0c, 6'h00);
        cyc("andi_if", 4'd0, w_if, 1'b0);
        cyc("andi_id", 4'd1, w_id, 1'b0);
        cyc("andi_exec", 4'd6, w_andi, 1'b0);
        cyc("andi_aluwb", 4'd7, w_aluwb_i, 1'b0);
        set_instr(6'h0b, 6'h00);
        cyc("sltiu_if", 4'd0, w_if, 1'b0);
        cyc("sltiu_id", 4'd1, w_id, 1'b0);
        cyc("sltiu_exec", 4'd6, w_sltiu, 1'b0);
        cyc("sltiu_aluwb", 4'd7, w_aluwb_i, 1'b0);
        set_instr(6'h08, 6'h00);
        cyc("addi_if", 4'd0, w_if, 1'b0);
        cyc("addi_id", 4'd1, w_id, 1'b0);
        cyc("addi_exec", 4'd6, w_addi, 1'b0);
        cyc("addi_aluwb", 4'd7, w_aluwb_i, 1'b0);
        set_instr(6'h0f, 6'h00);
        cyc("lui_if", 4'd0, w_if, 1'b0);
        cyc("lui_id", 4'd1, w_id, 1'b0);
        cyc("lui_exec", 4'd6, w_lui, 1'b0);
        cyc("lui_aluwb", 4'd7, w_aluwb_i, 1'b0);

        // Reset asserted mid-lw in MEMRD: read suppressed, back to IF.
        set_instr(6'h23, 6'h00);
        cyc("lwr_if", 4'd0, w_if, 1'b0);
        cyc("lwr_id", 4'd1, w_id, 1'b0);
        cyc("lwr_memadr", 4'd2, w_memadr, 1'b0);
        reset = 1'b0;
        cyc("lwr_memrd_rst", 4'd3, w_memrd_rst, 1'b0);
        cyc("lwr_after_rst", 4'd0, w_rst, 1'b0);
        reset = 1'b1;

        // Illegal opcode.
        set_instr(6'h3f, 6'h00);
        cyc("ill_if", 4'd0, w_if, 1'b0);
        cyc("ill_id", 4'd1, w_id, 1'b0);
`ifdef ILLEGAL_OP_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            cyc("ill_halt", 4'd15, w_zero, 1'b1);
        end
        reset = 1'b0;
        cyc("ill_halt_rst", 4'd15, w_zero, 1'b1);
        cyc("ill_cleared", 4'd0, w_rst, 1'b0);
        reset = 1'b1;
`endif

        // Recovery: beq after the illegal opcode.
        set_instr(6'h04, 6'h00);
        cyc("post_if", 4'd0, w_if, 1'b0);
        cyc("post_id", 4'd1, w_id, 1'b0);
        cyc("post_branch", 4'd8, w_branch, 1'b0);
        cyc("post_next_if", 4'd0, w_if, 1'b0);

        // Every pushed expectation must have been consumed by the monitor.
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
